uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default word width and clk_div floor.
// Also consumed by uart_tx so both directions agree on framing limits.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 16;
  localparam int UART_MAX_BITS   = 16;
  localparam logic [15:0] UART_MIN_CLK_DIV = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  // A divider below the floor cannot place a sample inside the bit cell.
  function automatic logic [15:0] eff_clk_div(input logic [15:0] raw);
    return (raw < UART_MIN_CLK_DIV) ? UART_MIN_CLK_DIV : raw;
  endfunction

  function automatic logic [4:0] eff_bits(input logic [4:0] raw);
    return ((raw == 5'd0) || (raw > 5'(UART_MAX_BITS))) ? 5'(UART_MAX_BITS) : raw;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line, frame configuration, and the word/status outputs.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

  logic                  rx;
  logic [15:0]           clk_div;
  logic [4:0]            bits_per_word;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  new_data;
  logic                  data_ready;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rx, clk_div, bits_per_word, rd_en,
    input  data_out, new_data, data_ready, busy, frame_err, overrun
  );

  modport slave (
    input  rx, clk_div, bits_per_word, rd_en,
    output data_out, new_data, data_ready, busy, frame_err, overrun
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; expire is high during the last cycle of a loaded count.
module uart_baud_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Loading value N makes expire rise N-1 cycles later, so the owner acts exactly N cycles on.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized rx, mid-bit sampling, LSB-first words of 1..16 bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  logic                  rx_meta_q;
  logic                  rx_sync_q;
  uart_state_e           state_q;
  uart_state_e           state_d;
  logic [15:0]           clk_div_q;
  logic [15:0]           clk_div_d;
  logic [4:0]            bpw_q;
  logic [4:0]            bpw_d;
  logic [4:0]            bit_cnt_q;
  logic [4:0]            bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  new_data_q;
  logic                  new_data_d;
  logic                  data_ready_q;
  logic                  data_ready_d;
  logic                  frame_err_q;
  logic                  frame_err_d;
  logic                  overrun_q;
  logic                  overrun_d;

  logic                  baud_load;
  logic [15:0]           baud_val;
  logic                  baud_expire;
  logic                  shift_clear;
  logic                  sample_bit;
  logic [15:0]           in_clk_div;
  logic                  last_bit;

  assign in_clk_div = eff_clk_div(bus.clk_div);
  assign last_bit   = (bit_cnt_q == (bpw_q - 5'd1));

  uart_baud_cnt #(
    .WIDTH(16)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (baud_load),
    .load_val(baud_val),
    .expire  (baud_expire)
  );

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (baud_expire) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (baud_expire && last_bit) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_expire) state_d = rx_sync_q ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_div_d    = clk_div_q;
    bpw_d        = bpw_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    new_data_d   = 1'b0;
    data_ready_d = data_ready_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    baud_load    = 1'b0;
    baud_val     = clk_div_q;
    shift_clear  = 1'b0;
    sample_bit   = 1'b0;

    if (bus.rd_en) data_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          clk_div_d   = in_clk_div;
          bpw_d       = eff_bits(bus.bits_per_word);
          bit_cnt_d   = 5'd0;
          shift_clear = 1'b1;
          baud_load   = 1'b1;
          baud_val    = in_clk_div >> 1;
        end
      end
      ST_START: begin
        if (baud_expire && !rx_sync_q) baud_load = 1'b1;
      end
      ST_DATA: begin
        if (baud_expire) begin
          sample_bit = 1'b1;
          bit_cnt_d  = bit_cnt_q + 5'd1;
          baud_load  = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_expire) begin
          if (rx_sync_q) begin
            data_out_d   = shift_q;
            new_data_d   = 1'b1;
            // A same-cycle acknowledge consumed the old word, so nothing was lost.
            overrun_d    = data_ready_q && !bus.rd_en;
            data_ready_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Bit i of the word lands directly at index i, giving a right-aligned result.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
    assign shift_d[gi] = shift_clear ? 1'b0 :
                         (sample_bit && (bit_cnt_q == 5'(gi))) ? rx_sync_q :
                         shift_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q    <= '0;
      bpw_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      new_data_q   <= 1'b0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      clk_div_q    <= clk_div_d;
      bpw_q        <= bpw_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      new_data_q   <= new_data_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.new_data   = new_data_q;
  assign bus.data_ready = data_ready_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames with a scoreboard: stimulus queues expected events, a monitor pops them.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit          is_ferr;
    logic [15:0] data;
    bit          ovr;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_if #(.DATA_WIDTH(16)) bus ();

  uart_rx #(.DATA_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && (bus.new_data || bus.frame_err || bus.overrun)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_txn: got new_data=%0b frame_err=%0b overrun=%0b data=%h at cycle %0d, expected no event",
                 bus.new_data, bus.frame_err, bus.overrun, bus.data_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_ferr ? (bus.frame_err && !bus.new_data && !bus.overrun)
                          : (bus.new_data && !bus.frame_err && bus.data_out === mon_e.data &&
                             bus.overrun === mon_e.ovr && (mon_e.at_cyc < 0 || cyc == mon_e.at_cyc))) begin
          $display("rx_txn ok: ferr=%0b data=%h overrun=%0b cycle=%0d",
                   bus.frame_err, bus.data_out, bus.overrun, cyc);
        end else begin
          errors++;
          $display("FAIL rx_txn: got new_data=%0b frame_err=%0b data=%h overrun=%0b cycle=%0d, expected ferr=%0b data=%h overrun=%0b cycle=%0d",
                   bus.new_data, bus.frame_err, bus.data_out, bus.overrun, cyc,
                   mon_e.is_ferr, mon_e.data, mon_e.ovr, mon_e.at_cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("check %s ok: %h", name, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queues the expected event, then drives start, data bits LSB first, and stop.
  task automatic send_frame(input logic [15:0] data, input int d, input int nb,
                            input logic stop_val, input bit ovr, input int lat);
    exp_t e;
    @(negedge clk);
    e.is_ferr = (stop_val == 1'b0);
    e.data    = data;
    e.ovr     = ovr;
    e.at_cyc  = (lat > 0) ? cyc + lat : -1;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    wait_cycles(d);
    for (int i = 0; i < nb; i++) begin
      bus.rx = data[i];
      wait_cycles(d);
    end
    bus.rx = stop_val;
    wait_cycles(d);
    if (stop_val) wait_cycles(10);
  endtask

  task automatic pulse_rd_en();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.rx            = 1'b1;
    bus.clk_div       = 16'd16;
    bus.bits_per_word = 5'd8;
    bus.rd_en         = 1'b0;
    rst               = 1'b1;
    wait_cycles(4);
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_data_ready", 32'(bus.data_ready), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_pulses", {29'd0, bus.new_data, bus.frame_err, bus.overrun}, 32'h0);
    rst = 1'b0;
    wait_cycles(3);

    // 0x50, 16 cycles/bit, 8 bits: 2 + 8 + 9*16 + 1 = 155 cycles
    send_frame(16'h0050, 16, 8, 1'b1, 1'b0, 155);
    check("f1_data_out", 32'(bus.data_out), 32'h0050);
    check("f1_data_ready", 32'(bus.data_ready), 32'h1);
    pulse_rd_en();
    check("f1_rd_en_clears", 32'(bus.data_ready), 32'h0);

    // 0xA5C3, 4 cycles/bit, 16 bits: 2 + 2 + 17*4 + 1 = 73 cycles
    bus.clk_div       = 16'd4;
    bus.bits_per_word = 5'd16;
    send_frame(16'hA5C3, 4, 16, 1'b1, 1'b0, 73);
    check("f2_data_out", 32'(bus.data_out), 32'hA5C3);
    check("f2_data_ready", 32'(bus.data_ready), 32'h1);
    pulse_rd_en();
    check("f2_rd_en_clears", 32'(bus.data_ready), 32'h0);

    // 3-cycle glitch must be rejected at the start-bit center
    bus.clk_div       = 16'd16;
    bus.bits_per_word = 5'd8;
    @(negedge clk);
    bus.rx = 1'b0;
    wait_cycles(3);
    bus.rx = 1'b1;
    wait_cycles(1);
    check("glitch_busy_high", 32'(bus.busy), 32'h1);
    wait_cycles(20);
    check("glitch_busy_low", 32'(bus.busy), 32'h0);

    // Low stop bit, line held low afterwards (break)
    send_frame(16'h003C, 16, 8, 1'b0, 1'b0, 0);
    wait_cycles(20);
    check("ferr_busy_held", 32'(bus.busy), 32'h1);
    check("ferr_data_out_kept", 32'(bus.data_out), 32'hA5C3);
    check("ferr_data_ready_kept", 32'(bus.data_ready), 32'h0);
    bus.rx = 1'b1;
    wait_cycles(6);
    check("ferr_busy_released", 32'(bus.busy), 32'h0);

    // Two words without acknowledge: the second overruns
    bus.clk_div = 16'd8;
    send_frame(16'h0011, 8, 8, 1'b1, 1'b0, 0);
    send_frame(16'h0022, 8, 8, 1'b1, 1'b1, 0);
    check("ovr_data_out", 32'(bus.data_out), 32'h0022);
    check("ovr_data_ready", 32'(bus.data_ready), 32'h1);

    // Reset in the middle of 0x7E's data bits, then 0x81 with clk_div 0 (acts as 2)
    bus.clk_div       = 16'd0;
    bus.bits_per_word = 5'd8;
    @(negedge clk);
    bus.rx = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 4; i++) begin
      bus.rx = ((8'h7E >> i) & 8'h01) != 8'h00;
      wait_cycles(2);
    end
    rst    = 1'b1;
    bus.rx = 1'b1;
    wait_cycles(3);
    check("midrst_data_out", 32'(bus.data_out), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_data_ready", 32'(bus.data_ready), 32'h0);
    rst = 1'b0;
    wait_cycles(5);
    // 2 + 1 + 9*2 + 1 = 22 cycles
    send_frame(16'h0081, 2, 8, 1'b1, 1'b0, 22);
    check("div0_data_out", 32'(bus.data_out), 32'h0081);

    wait_cycles(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
